// File: rtl/ws2812_rx.sv
// ws2812_rx: receiver/decoder for the WS2812 single-wire LED protocol.
//   Oversamples data_i, classifies each high pulse as a 0 or 1 bit by its
//   width, assembles 24-bit GRB pixels (MSB first) and writes each pixel out
//   through address_o/we_o. A long low gap delimits frames.
//
// Ports:
//   clk_i        system clock
//   rst_ni       asynchronous active-low reset
//   data_i       WS2812 serial line, asynchronous to clk_i
//   address_o    pixel index of the current write
//   r_o/g_o/b_o  decoded colour, valid while we_o, held between strobes
//   we_o         one-cycle write strobe per completed pixel
//   frame_done_o one-cycle pulse when a reset gap terminates a frame
//   error_o      one-cycle pulse on a protocol violation
//   data_o       cascade output
//
// Build option: define WS2812_RX_FORWARD_EN to forward the synchronized line
//   on data_o once LED_COUNT pixels have been captured. When undefined,
//   data_o is tied low and no forwarding logic exists.

module ws2812_rx #(
  parameter int unsigned LED_COUNT        = 256,
  parameter int unsigned CYCLES_MIN_HIGH  = 5,
  parameter int unsigned CYCLES_THRESHOLD = 31,
  parameter int unsigned CYCLES_MAX_HIGH  = 60,
  parameter int unsigned CYCLES_RESET     = 2500
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       data_i,
  output logic [8:0] address_o,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o,
  output logic       we_o,
  output logic       frame_done_o,
  output logic       error_o,
  output logic       data_o
);

  localparam int unsigned CNT_W = 12;
  localparam int unsigned HW    = CNT_W + 1;
  localparam int unsigned IDX_W = 10;
  localparam int unsigned BIT_W = 5;
  localparam int unsigned PIX_W = 24;

  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(4095);
  localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(CYCLES_RESET);
  localparam logic [HW-1:0]    MIN_H     = HW'(CYCLES_MIN_HIGH);
  localparam logic [HW-1:0]    THR_H     = HW'(CYCLES_THRESHOLD);
  localparam logic [HW-1:0]    MAX_H     = HW'(CYCLES_MAX_HIGH);
  localparam logic [IDX_W-1:0] LED_CNT   = IDX_W'(LED_COUNT);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(PIX_W - 1);

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  // Synchronizer, edge-detect flop and shared width counter
  logic             sync1_q;
  logic             sync2_q;
  logic             edge_q;
  logic [CNT_W-1:0] cnt_q;

  // Decoder state
  logic [1:0]       state_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [PIX_W-1:0] shreg_q;
  logic [IDX_W-1:0] pix_idx_q;
  logic             pend_q;

  // Combinational next values
  logic             edge_c;
  logic             rise_c;
  logic             fall_c;
  logic             gap_c;
  logic [HW-1:0]    h_c;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       state_d;
  logic [BIT_W-1:0] bit_cnt_d;
  logic [PIX_W-1:0] shreg_d;
  logic [IDX_W-1:0] pix_idx_d;
  logic             pend_d;
  logic [8:0]       address_d;
  logic [7:0]       r_d;
  logic [7:0]       g_d;
  logic [7:0]       b_d;
  logic             we_d;
  logic             frame_done_d;
  logic             error_d;

  // Edge detection and width counter; h_c is the width of the current level
  // in cycles, including the present one.
  always_comb begin
    edge_c = sync2_q ^ edge_q;
    rise_c = sync2_q & ~edge_q;
    fall_c = ~sync2_q & edge_q;
    if (edge_c) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_SAT) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    h_c   = HW'(cnt_q) + HW'(1);
    // Fires once, on the cycle the steady low reaches the reset length
    gap_c = !edge_c && !sync2_q && (cnt_d == RESET_CNT);
  end

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    pix_idx_d    = pix_idx_q;
    pend_d       = 1'b0;
    address_d    = address_o;
    r_d          = r_o;
    g_d          = g_o;
    b_d          = b_o;
    we_d         = 1'b0;
    frame_done_d = 1'b0;
    error_d      = 1'b0;

    // Pixel write stage: one cycle after the 24th bit was shifted in
    if (pend_q && (pix_idx_q < LED_CNT)) begin
      we_d      = 1'b1;
      address_d = pix_idx_q[8:0];
      g_d       = shreg_q[23:16];
      r_d       = shreg_q[15:8];
      b_d       = shreg_q[7:0];
      pix_idx_d = pix_idx_q + IDX_W'(1);
    end

    case (state_q)
      ST_SYNC: begin
        if (gap_c) begin
          state_d   = ST_IDLE;
          bit_cnt_d = '0;
          pix_idx_d = '0;
        end
      end

      ST_IDLE, ST_LOW: begin
        if (rise_c) begin
          state_d = ST_HIGH;
        end else if (gap_c) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
          error_d      = (bit_cnt_q != '0);
          bit_cnt_d    = '0;
          pix_idx_d    = '0;
        end
      end

      ST_HIGH: begin
        if (fall_c) begin
          if ((h_c < MIN_H) || (h_c >= MAX_H)) begin
            state_d   = ST_SYNC;
            error_d   = 1'b1;
            bit_cnt_d = '0;
          end else begin
            state_d = ST_LOW;
            shreg_d = {shreg_q[PIX_W-2:0], (h_c >= THR_H)};
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d = '0;
              pend_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end else if (h_c >= MAX_H) begin
          // Stuck high: flag now rather than waiting for the fall
          state_d   = ST_SYNC;
          error_d   = 1'b1;
          bit_cnt_d = '0;
        end
      end

      default: begin
        state_d   = ST_SYNC;
        bit_cnt_d = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      edge_q       <= 1'b0;
      cnt_q        <= '0;
      state_q      <= ST_SYNC;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      pix_idx_q    <= '0;
      pend_q       <= 1'b0;
      address_o    <= '0;
      r_o          <= '0;
      g_o          <= '0;
      b_o          <= '0;
      we_o         <= 1'b0;
      frame_done_o <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      sync1_q      <= data_i;
      sync2_q      <= sync1_q;
      edge_q       <= sync2_q;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      pix_idx_q    <= pix_idx_d;
      pend_q       <= pend_d;
      address_o    <= address_d;
      r_o          <= r_d;
      g_o          <= g_d;
      b_o          <= b_d;
      we_o         <= we_d;
      frame_done_o <= frame_done_d;
      error_o      <= error_d;
    end
  end

`ifdef WS2812_RX_FORWARD_EN
  // Registered from sync1 so data_o matches the 2-flop synchronized line,
  // gated by the index value that becomes current in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o <= 1'b0;
    end else begin
      data_o <= sync1_q & (pix_idx_d == LED_CNT);
    end
  end
`else
  assign data_o = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812_rx.sv
module tb_ws2812_rx;

  localparam int unsigned LEDS = 4;

  logic       clk;
  logic       rst_n;
  logic       data;
  logic [8:0] address;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       we;
  logic       frame_done;
  logic       error;
  logic       data_out;

  ws2812_rx #(.LED_COUNT(LEDS)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .data_i       (data),
    .address_o    (address),
    .r_o          (r),
    .g_o          (g),
    .b_o          (b),
    .we_o         (we),
    .frame_done_o (frame_done),
    .error_o      (error),
    .data_o       (data_out)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Event monitor
  int cyc = 0;
  int we_cnt = 0, fd_cnt = 0, err_cnt = 0;
  int we_cyc = 0, fd_cyc = 0, err_cyc = 0;
  int last_fall = 0, last_rise = 0;
  logic [8:0]  wr_addr[$];
  logic [23:0] wr_grb[$];
  logic hist0 = 1'b0, hist1 = 1'b0;
  bit   fwd_win = 1'b0;
  int   fwd_seen = 0, fwd_bad = 0, dout_high = 0;

  always @(posedge clk) begin
    cyc++;
    hist1 = hist0;
    hist0 = data;
  end

  always @(negedge clk) begin
    if (we === 1'b1) begin
      we_cnt++;
      we_cyc = cyc;
      wr_addr.push_back(address);
      wr_grb.push_back({g, r, b});
    end
    if (frame_done === 1'b1) begin fd_cnt++;  fd_cyc = cyc;  end
    if (error === 1'b1)      begin err_cnt++; err_cyc = cyc; end
    if (data_out !== 1'b0) dout_high++;
    if (fwd_win) begin
      fwd_seen++;
      if (data_out !== hist1) fwd_bad++;
    end
  end

  // Stimulus primitives: every drive starts 1 time unit after a rising edge
  task automatic drive(input logic v, input int n);
    data = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit_w(input int h, input int l);
    last_rise = cyc;
    drive(1'b1, h);
    last_fall = cyc;
    drive(1'b0, l);
  endtask

  task automatic send_pixel(input logic [23:0] v);
    for (int i = 23; i >= 0; i--) begin
      if (v[i]) send_bit_w(42, 21);
      else      send_bit_w(21, 42);
    end
  endtask

  function automatic logic [8:0] addr_at(input int k);
    if (wr_addr.size() > k) return wr_addr[k];
    return 9'h1ff;
  endfunction

  function automatic logic [23:0] grb_at(input int k);
    if (wr_grb.size() > k) return wr_grb[k];
    return 24'hxxxxxx;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    data  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({we, frame_done, error, data_out} !== 4'b0000)
      $display("FAIL reset_strobes: got %b expected 0000", {we, frame_done, error, data_out});
    else n_pass++;
    n_checks++;
    if ({address, r, g, b} !== 33'h0)
      $display("FAIL reset_data: got %h expected 0", {address, r, g, b});
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_pixel;
    int we0, fd0, err0, q0;
    we0 = we_cnt; fd0 = fd_cnt; err0 = err_cnt; q0 = wr_addr.size();
    drive(1'b0, 3000);
    send_pixel(24'hA53C0F);
    drive(1'b0, 3000);
    n_checks++;
    if (we_cnt - we0 != 1) $display("FAIL single_we_count: got %0d expected 1", we_cnt - we0);
    else n_pass++;
    n_checks++;
    if (addr_at(q0) !== 9'd0) $display("FAIL single_addr: got %0d expected 0", addr_at(q0));
    else n_pass++;
    n_checks++;
    if (grb_at(q0) !== 24'hA53C0F) $display("FAIL single_grb: got %h expected a53c0f", grb_at(q0));
    else n_pass++;
    n_checks++;
    if (we_cyc - last_fall != 4) $display("FAIL single_we_latency: got %0d expected 4", we_cyc - last_fall);
    else n_pass++;
    n_checks++;
    if (fd_cnt - fd0 != 1) $display("FAIL single_fd_count: got %0d expected 1", fd_cnt - fd0);
    else n_pass++;
    // fall detected 3 clk after the drive, frame_done 2500 clk after that
    n_checks++;
    if (fd_cyc - last_fall != 2503) $display("FAIL single_fd_latency: got %0d expected 2503", fd_cyc - last_fall);
    else n_pass++;
    n_checks++;
    if (err_cnt - err0 != 0) $display("FAIL single_err: got %0d expected 0", err_cnt - err0);
    else n_pass++;
  endtask

  task automatic test_overflow;
    int we0, fd0, err0, q0;
    we0 = we_cnt; fd0 = fd_cnt; err0 = err_cnt; q0 = wr_addr.size();
    drive(1'b0, 100);
    for (int p = 0; p < 4; p++) send_pixel(24'hFFFFFF);
    fwd_win = 1'b1;
    for (int p = 0; p < 2; p++) send_pixel(24'hFFFFFF);
    fwd_win = 1'b0;
    drive(1'b0, 3000);
    n_checks++;
    if (we_cnt - we0 != 4) $display("FAIL ovf_we_count: got %0d expected 4", we_cnt - we0);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (addr_at(q0 + k) !== 9'(k)) $display("FAIL ovf_addr%0d: got %0d expected %0d", k, addr_at(q0 + k), k);
      else n_pass++;
    end
    n_checks++;
    if (grb_at(q0 + 3) !== 24'hFFFFFF) $display("FAIL ovf_grb: got %h expected ffffff", grb_at(q0 + 3));
    else n_pass++;
    n_checks++;
    if (fd_cnt - fd0 != 1) $display("FAIL ovf_fd: got %0d expected 1", fd_cnt - fd0);
    else n_pass++;
    n_checks++;
    if (err_cnt - err0 != 0) $display("FAIL ovf_err: got %0d expected 0", err_cnt - err0);
    else n_pass++;
`ifdef WS2812_RX_FORWARD_EN
    n_checks++;
    if (fwd_bad != 0 || fwd_seen == 0)
      $display("FAIL fwd_mirror: got %0d bad of %0d samples expected 0 bad", fwd_bad, fwd_seen);
    else n_pass++;
`else
    n_checks++;
    if (dout_high != 0) $display("FAIL dout_tied: got %0d high samples expected 0", dout_high);
    else n_pass++;
`endif
  endtask

  task automatic test_partial;
    int we0, fd0, err0, q0;
    we0 = we_cnt; fd0 = fd_cnt; err0 = err_cnt;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) send_bit_w(42, 21);
      else            send_bit_w(21, 42);
    end
    drive(1'b0, 3000);
    n_checks++;
    if (fd_cnt - fd0 != 1 || err_cnt - err0 != 1)
      $display("FAIL partial_counts: got fd %0d err %0d expected 1 1", fd_cnt - fd0, err_cnt - err0);
    else n_pass++;
    n_checks++;
    if (fd_cyc != err_cyc) $display("FAIL partial_same_cycle: got fd@%0d err@%0d expected equal", fd_cyc, err_cyc);
    else n_pass++;
    n_checks++;
    if (we_cnt - we0 != 0) $display("FAIL partial_no_we: got %0d expected 0", we_cnt - we0);
    else n_pass++;
    q0 = wr_addr.size();
    send_pixel(24'h123456);
    drive(1'b0, 3000);
    n_checks++;
    if (addr_at(q0) !== 9'd0 || grb_at(q0) !== 24'h123456)
      $display("FAIL partial_next: got addr %0d grb %h expected 0 123456", addr_at(q0), grb_at(q0));
    else n_pass++;
  endtask

  task automatic test_glitch;
    int we0, fd0, err0, q0;
    we0 = we_cnt; fd0 = fd_cnt; err0 = err_cnt;
    for (int i = 0; i < 5; i++) send_bit_w(42, 21);
    send_bit_w(3, 42);
    n_checks++;
    if (err_cnt - err0 != 1) $display("FAIL glitch_err: got %0d expected 1", err_cnt - err0);
    else n_pass++;
    send_pixel(24'hFFFFFF);
    drive(1'b0, 3000);
    n_checks++;
    if (err_cnt - err0 != 1 || we_cnt - we0 != 0 || fd_cnt - fd0 != 0)
      $display("FAIL glitch_ignored: got err %0d we %0d fd %0d expected 1 0 0",
               err_cnt - err0, we_cnt - we0, fd_cnt - fd0);
    else n_pass++;
    q0 = wr_addr.size();
    send_pixel(24'h00FF00);
    drive(1'b0, 3000);
    n_checks++;
    if (addr_at(q0) !== 9'd0 || grb_at(q0) !== 24'h00FF00)
      $display("FAIL glitch_recover: got addr %0d grb %h expected 0 00ff00", addr_at(q0), grb_at(q0));
    else n_pass++;
  endtask

  task automatic test_threshold;
    int we0, err0, q0;
    we0 = we_cnt; err0 = err_cnt; q0 = wr_addr.size();
    // 22 zeros, then 30-clk high (0) and 31-clk high (1)
    for (int i = 0; i < 22; i++) send_bit_w(21, 42);
    send_bit_w(30, 33);
    send_bit_w(31, 32);
    // 31-clk high (1), 30-clk high (0), 22 zeros
    send_bit_w(31, 32);
    send_bit_w(30, 33);
    for (int i = 0; i < 22; i++) send_bit_w(21, 42);
    // 5-clk high (0, shortest legal), 22 ones, 59-clk high (1, longest legal)
    send_bit_w(5, 40);
    for (int i = 0; i < 22; i++) send_bit_w(42, 21);
    send_bit_w(59, 21);
    drive(1'b0, 3000);
    n_checks++;
    if (we_cnt - we0 != 3) $display("FAIL thr_we_count: got %0d expected 3", we_cnt - we0);
    else n_pass++;
    n_checks++;
    if (grb_at(q0) !== 24'h000001) $display("FAIL thr_30_31: got %h expected 000001", grb_at(q0));
    else n_pass++;
    n_checks++;
    if (grb_at(q0 + 1) !== 24'h800000) $display("FAIL thr_31_30: got %h expected 800000", grb_at(q0 + 1));
    else n_pass++;
    n_checks++;
    if (grb_at(q0 + 2) !== 24'h7FFFFF || addr_at(q0 + 2) !== 9'd2)
      $display("FAIL thr_min_max: got addr %0d grb %h expected 2 7fffff", addr_at(q0 + 2), grb_at(q0 + 2));
    else n_pass++;
    n_checks++;
    if (err_cnt - err0 != 0) $display("FAIL thr_err: got %0d expected 0", err_cnt - err0);
    else n_pass++;
  endtask

  task automatic test_max_high;
    int err0;
    err0 = err_cnt;
    send_bit_w(60, 42);
    n_checks++;
    if (err_cnt - err0 != 1) $display("FAIL max60_err: got %0d expected 1", err_cnt - err0);
    else n_pass++;
    drive(1'b0, 3000);
    err0 = err_cnt;
    send_bit_w(80, 3000);
    n_checks++;
    if (err_cnt - err0 != 1) $display("FAIL stuck_high_err: got %0d expected 1", err_cnt - err0);
    else n_pass++;
    // rise seen after 3 clk, count hits 60 while high, pulse registered
    n_checks++;
    if (err_cyc - last_rise != 63) $display("FAIL stuck_high_time: got %0d expected 63", err_cyc - last_rise);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int we0, q0;
    q0 = wr_addr.size();
    send_pixel(24'h0A0B0C);
    drive(1'b0, 10);
    n_checks++;
    if (grb_at(q0) !== 24'h0A0B0C) $display("FAIL rstmid_pre: got %h expected 0a0b0c", grb_at(q0));
    else n_pass++;
    rst_n = 1'b0;
    #2;
    n_checks++;
    if ({address, r, g, b, we, frame_done, error} !== 36'h0)
      $display("FAIL rstmid_clear: got %h expected 0", {address, r, g, b, we, frame_done, error});
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    we0 = we_cnt;
    for (int p = 0; p < 3; p++) send_pixel(24'hC0FFEE);
    n_checks++;
    if (we_cnt - we0 != 0) $display("FAIL rstmid_resync: got %0d writes expected 0", we_cnt - we0);
    else n_pass++;
    drive(1'b0, 3000);
    q0 = wr_addr.size();
    send_pixel(24'h0D0E0F);
    drive(1'b0, 3000);
    n_checks++;
    if (addr_at(q0) !== 9'd0 || grb_at(q0) !== 24'h0D0E0F)
      $display("FAIL rstmid_resume: got addr %0d grb %h expected 0 0d0e0f", addr_at(q0), grb_at(q0));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_overflow();
    test_partial();
    test_glitch();
    test_threshold();
    test_max_high();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
